mips_multicycle_core: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle core.
- One shared memory port with a req/ready handshake replaces separate instruction and data memories, so wait-state memories are supported.
- An internal FSM sequences fetch, decode, execute, memory and write-back.
- It has a reset, selectable word/byte PC addressing and an illegal-instruction halt.
- Debug outputs mirror the existing core's: instruction, ALUResult, write_reg, RegWrite.

---
 rtl/mips_multicycle_core.sv | 155 +++++++++++++++
 tb/tb_mips_multicycle_core.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_core.sv
// rtl/mips_multicycle_core.sv - multi-cycle MIPS subset core with one shared req/ready memory port
module mips_multicycle_core #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BYTE_ADDR = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       instruction,
  output logic [31:0]       ALUResult,
  output logic [4:0]        write_reg,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, state_n;

  localparam logic [ADDR_W-1:0] STEP     = (BYTE_ADDR != 0) ? ADDR_W'(4) : ADDR_W'(1);
  localparam int                J_BITS   = (BYTE_ADDR != 0) ? 28 : 26;
  localparam logic [63:0]       J_MASK64 = (64'd1 << J_BITS) - 64'd1;
  localparam logic [ADDR_W-1:0] J_MASK   = J_MASK64[ADDR_W-1:0];

  logic [31:0]       gpr [32];
  logic [31:0]       rs_val, rt_val, imm_ext, load_data, alu_b, alu_out, br_off;
  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm;
  logic [25:0]       target;
  logic              is_rtype, is_lw, is_sw, is_beq, is_bne, is_j, is_zext, legal, taken;
  logic [ADDR_W-1:0] br_pc, j_pc;
  logic [63:0]       j_field;
  logic              unused_j_bits;

  assign {opcode, rs, rt, rd, shamt, funct} = instruction;
  assign imm      = instruction[15:0];
  assign target   = instruction[25:0];
  assign is_rtype = (opcode == 6'h00);
  assign is_lw    = (opcode == 6'h23);
  assign is_sw    = (opcode == 6'h2B);
  assign is_beq   = (opcode == 6'h04);
  assign is_bne   = (opcode == 6'h05);
  assign is_j     = (opcode == 6'h02);
  assign is_zext  = (opcode == 6'h0C) || (opcode == 6'h0D);
  assign legal    = is_rtype ? (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02})
                             : (opcode inside {6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02});

  // pc already points past the branch when EXEC runs, so the offset is relative to pc+STEP
  assign taken   = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val);
  assign br_off  = (BYTE_ADDR != 0) ? (imm_ext << 2) : imm_ext;
  assign br_pc   = pc + br_off[ADDR_W-1:0];
  assign j_field = (BYTE_ADDR != 0) ? {36'd0, target, 2'b00} : {38'd0, target};
  assign j_pc    = (pc & ~J_MASK) | (j_field[ADDR_W-1:0] & J_MASK);
  assign unused_j_bits = ^j_field[63:ADDR_W];

  always_comb begin
    alu_b   = is_rtype ? rt_val : (is_zext ? {16'h0, imm_ext[15:0]} : imm_ext);
    alu_out = rs_val + alu_b;
    if (is_rtype) begin
      case (funct)
        6'h22:   alu_out = rs_val - alu_b;
        6'h24:   alu_out = rs_val & alu_b;
        6'h25:   alu_out = rs_val | alu_b;
        6'h2A:   alu_out = {31'h0, $signed(rs_val) < $signed(alu_b)};
        6'h00:   alu_out = rt_val << shamt;
        6'h02:   alu_out = rt_val >> shamt;
        default: ;
      endcase
    end else if (opcode == 6'h0C) begin
      alu_out = rs_val & alu_b;
    end else if (opcode == 6'h0D) begin
      alu_out = rs_val | alu_b;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= state_n;
  end

  // request is gated by reset_n so it drops the instant reset asserts
  always_comb begin
    state_n   = state;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc;
    mem_wdata = rt_val;
    RegWrite  = 1'b0;
    halted    = (state == HALT);
    case (state)
      FETCH: begin
        mem_req = reset_n;
        if (mem_ready) state_n = DECODE;
      end
      DECODE: state_n = legal ? EXEC : HALT;
      EXEC: begin
        if (is_lw || is_sw)               state_n = MEM;
        else if (is_beq || is_bne || is_j) state_n = FETCH;
        else                              state_n = WB;
      end
      MEM: begin
        mem_req  = reset_n;
        mem_we   = reset_n && is_sw;
        mem_addr = ALUResult[ADDR_W-1:0];
        if (mem_ready) state_n = is_sw ? FETCH : WB;
      end
      WB: begin
        RegWrite = (write_reg != 5'd0);
        state_n  = FETCH;
      end
      default: state_n = HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      instruction <= '0;
      ALUResult   <= '0;
      write_reg   <= '0;
      rs_val      <= '0;
      rt_val      <= '0;
      imm_ext     <= '0;
      load_data   <= '0;
      for (int i = 0; i < 32; i++) gpr[i] <= '0;
    end else begin
      case (state)
        FETCH: if (mem_ready) begin
          instruction <= mem_rdata;
          pc          <= pc + STEP;
        end
        DECODE: if (legal) begin
          rs_val    <= gpr[rs];
          rt_val    <= gpr[rt];
          imm_ext   <= {{16{imm[15]}}, imm};
          write_reg <= is_rtype ? rd : rt;
        end
        EXEC: begin
          if (taken)                     pc <= br_pc;
          else if (is_j)                 pc <= j_pc;
          else if (!is_beq && !is_bne)   ALUResult <= alu_out;
        end
        MEM: if (mem_ready && !is_sw) load_data <= mem_rdata;
        WB: if (write_reg != 5'd0) gpr[write_reg] <= is_lw ? load_data : ALUResult;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb/tb_mips_multicycle_core.sv - randomized bench for mips_multicycle_core against an ISA-level model
module tb_mips_multicycle_core;
  localparam logic [31:0] RST_PC  = 32'h10;
  localparam logic [31:0] ILLEGAL = 32'hFC00_0000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        mem_req, mem_we, mem_ready, RegWrite, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, instruction, ALUResult, pc;
  logic [4:0]  write_reg;

  mips_multicycle_core #(.ADDR_W(32), .RESET_PC(RST_PC), .BYTE_ADDR(0)) dut (
    .clock(clock), .reset_n(reset_n), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .instruction(instruction),
    .ALUResult(ALUResult), .write_reg(write_reg), .RegWrite(RegWrite), .pc(pc), .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] data;} tx_t;
  typedef struct packed {logic [4:0] r; logic [31:0] v;} wb_t;

  int checks = 0, errors = 0;
  int wait_cfg = 0, wcnt = 0, unstable = 0, cycles = 0, exp_cycles = 0, wp = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] init_mem [0:1023];
  tx_t txq[$], exq[$], mon_cur, prev_tx;
  wb_t wbq[$], ewq[$];
  logic prev_pend = 1'b0;

  function automatic tx_t mk_tx(input logic we, input logic [31:0] a, input logic [31:0] d);
    tx_t t; t.we = we; t.addr = a; t.data = d; return t;
  endfunction
  function automatic wb_t mk_wb(input logic [4:0] r, input logic [31:0] v);
    wb_t w; w.r = r; w.v = v; return w;
  endfunction
  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction
  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction
  function automatic logic [31:0] enc_j(input int tgt);
    return {6'h02, 26'(tgt)};
  endfunction
  function automatic int tx_diff();
    if (txq.size() != exq.size()) return -2;
    foreach (txq[i]) if (txq[i] !== exq[i]) return i;
    return -1;
  endfunction
  function automatic int wb_diff();
    if (wbq.size() != ewq.size()) return -2;
    foreach (wbq[i]) if (wbq[i] !== ewq[i]) return i;
    return -1;
  endfunction

  // memory responder: fixed wait count per request, random ready while idle, logs every accepted transfer
  always @(negedge clock) begin
    mon_cur = mk_tx(mem_we, mem_addr, mem_we ? mem_wdata : 32'h0);
    if (reset_n && mem_req) begin
      if (prev_pend && mon_cur !== prev_tx) unstable++;
      if (wcnt >= wait_cfg) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:0]];
        txq.push_back(mon_cur);
        if (mem_we) mem[mem_addr[9:0]] = mem_wdata;
        wcnt = 0; prev_pend = 1'b0;
      end else begin
        mem_ready = 1'b0; mem_rdata = $urandom; wcnt++; prev_pend = 1'b1; prev_tx = mon_cur;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom; wcnt = 0; prev_pend = 1'b0;
    end
    if (reset_n && RegWrite) wbq.push_back(mk_wb(write_reg, ALUResult));
  end

  // instruction-set interpreter producing the expected transfer log, write-back log and cycle count
  task automatic model_run(input int waits);
    logic [31:0] r [32];
    logic [31:0] mm [1024];
    logic [31:0] p, ins, a, b, se, ze, v, ld;
    logic [4:0]  dst;
    logic        ill, wb;
    int          lat;
    for (int i = 0; i < 32; i++) r[i] = 32'h0;
    for (int i = 0; i < 1024; i++) mm[i] = init_mem[i];
    exq.delete(); ewq.delete(); exp_cycles = 0; p = RST_PC;
    for (int n = 0; n < 500; n++) begin
      ins = mm[p[9:0]];
      exq.push_back(mk_tx(1'b0, p, 32'h0));
      p = p + 1; exp_cycles += 1 + waits;
      a = r[ins[25:21]]; b = r[ins[20:16]];
      se = {{16{ins[15]}}, ins[15:0]}; ze = {16'h0, ins[15:0]};
      ill = 1'b0; wb = 1'b1; lat = 3; dst = ins[20:16]; v = 32'h0; ld = 32'h0;
      case (ins[31:26])
        6'h00: begin
          dst = ins[15:11];
          case (ins[5:0])
            6'h20: v = a + b;
            6'h22: v = a - b;
            6'h24: v = a & b;
            6'h25: v = a | b;
            6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h00: v = b << ins[10:6];
            6'h02: v = b >> ins[10:6];
            default: ill = 1'b1;
          endcase
        end
        6'h08: v = a + se;
        6'h0C: v = a & ze;
        6'h0D: v = a | ze;
        6'h23: begin v = a + se; exq.push_back(mk_tx(1'b0, v, 32'h0)); ld = mm[v[9:0]]; lat = 4 + waits; end
        6'h2B: begin v = a + se; exq.push_back(mk_tx(1'b1, v, b)); mm[v[9:0]] = b; lat = 3 + waits; wb = 1'b0; end
        6'h04: begin if (a == b) p = p + se; lat = 2; wb = 1'b0; end
        6'h05: begin if (a != b) p = p + se; lat = 2; wb = 1'b0; end
        6'h02: begin p = {p[31:26], ins[25:0]}; lat = 2; wb = 1'b0; end
        default: ill = 1'b1;
      endcase
      if (ill) begin exp_cycles += 1; break; end
      exp_cycles += lat;
      if (wb && dst != 5'd0) begin
        ewq.push_back(mk_wb(dst, v));
        r[dst] = (ins[31:26] == 6'h23) ? ld : v;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = ILLEGAL;
    wp = RST_PC;
  endtask
  task automatic put(input logic [31:0] w);
    mem[wp] = w; wp++;
  endtask

  task automatic run_program(input int waits);
    for (int i = 0; i < 1024; i++) init_mem[i] = mem[i];
    model_run(waits);
    reset_n = 1'b0; wait_cfg = waits;
    txq.delete(); wbq.delete(); unstable = 0;
    repeat (2) @(negedge clock);
    @(posedge clock); #1 reset_n = 1'b1;
    cycles = 0;
    while (1) begin
      @(posedge clock); cycles++;
      @(negedge clock);
      if (halted) break;
      if (cycles > 3000) begin
        checks++; errors++;
        $display("FAIL run_timeout: halted not reached after %0d cycles, required by %0d", cycles, exp_cycles);
        break;
      end
    end
  endtask

  task automatic test_reset();
    clear_mem(); put(enc_i(8, 0, 1, 5));
    wait_cfg = 0; reset_n = 1'b0;
    repeat (2) @(negedge clock); #1;
    checks++; if ({mem_req, mem_we, RegWrite, halted} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b required 0000", {mem_req, mem_we, RegWrite, halted}); end
    checks++; if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h required %h", pc, RST_PC); end
    checks++; if ({instruction, ALUResult, write_reg} !== 69'h0) begin errors++; $display("FAIL reset_regs: got %h %h %h required 0", instruction, ALUResult, write_reg); end
    wait_cfg = 5;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== RST_PC || mem_we !== 1'b0) begin errors++; $display("FAIL first_fetch_req: got req=%b addr=%h we=%b required 1 %h 0", mem_req, mem_addr, mem_we, RST_PC); end
    #1 reset_n = 1'b0; #1;
    checks++; if (mem_req !== 1'b0 || pc !== RST_PC) begin errors++; $display("FAIL reset_mid_fetch: got req=%b pc=%h required 0 %h", mem_req, pc, RST_PC); end
    wait_cfg = 0;
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock); @(negedge clock); #1;
    checks++; if (pc !== RST_PC + 1) begin errors++; $display("FAIL fetch_pc_step: got %h required %h", pc, RST_PC + 1); end
    checks++; if (instruction !== enc_i(8, 0, 1, 5)) begin errors++; $display("FAIL fetch_ir: got %h required %h", instruction, enc_i(8, 0, 1, 5)); end
  endtask

  task automatic test_alu();
    clear_mem();
    put(enc_i(8, 0, 1, 5)); put(enc_i(8, 0, 2, -3)); put(enc_r(1, 2, 3, 0, 'h20)); put(enc_r(2, 1, 4, 0, 'h2A)); put(ILLEGAL);
    run_program(0);
    checks++; if (cycles !== 18) begin errors++; $display("FAIL alu_cycles: got %0d required 18", cycles); end
    checks++; if (wbq.size() !== 4) begin errors++; $display("FAIL alu_wb_count: got %0d required 4", wbq.size()); end
    else begin
      checks++; if (wbq[2] !== mk_wb(3, 2)) begin errors++; $display("FAIL alu_add: got r%0d=%h required r3=2", wbq[2].r, wbq[2].v); end
      checks++; if (wbq[3] !== mk_wb(4, 1)) begin errors++; $display("FAIL alu_slt: got r%0d=%h required r4=1", wbq[3].r, wbq[3].v); end
    end
    checks++; if (wb_diff() !== -1) begin errors++; $display("FAIL alu_wb_trace: got diff at %0d required -1", wb_diff()); end
  endtask

  task automatic test_load_store();
    clear_mem();
    mem[8] = 32'h0; mem[12] = 32'h0;
    put(enc_i(8, 0, 3, 2)); put(enc_i('h2B, 0, 3, 8)); put(enc_i('h23, 0, 5, 8)); put(enc_i('h2B, 0, 5, 12)); put(ILLEGAL);
    run_program(3);
    checks++; if (cycles !== 43) begin errors++; $display("FAIL ls_cycles: got %0d required 43", cycles); end
    checks++; if (txq.size() < 3 || txq[2] !== mk_tx(1'b1, 32'd8, 32'd2)) begin errors++; $display("FAIL ls_store: got %h required we=1 addr=8 data=2", (txq.size() > 2) ? txq[2] : '0); end
    checks++; if (mem[12] !== 32'd2) begin errors++; $display("FAIL ls_load_value: got %h required 2", mem[12]); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL ls_stable: got %0d changes required 0", unstable); end
    checks++; if (tx_diff() !== -1) begin errors++; $display("FAIL ls_tx_trace: got diff at %0d required -1", tx_diff()); end
  endtask

  task automatic test_branch();
    int w;
    logic [31:0] exp_f [8];
    w = $urandom_range(0, 2);
    exp_f = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h1F, 32'h20, 32'h21, 32'h22};
    clear_mem();
    mem['h10] = enc_i(8, 0, 1, 1); mem['h11] = enc_i(8, 0, 2, 1); mem['h12] = enc_j('h20);
    mem['h1F] = enc_i(8, 2, 2, 1); mem['h20] = enc_i(4, 1, 2, -2); mem['h21] = enc_i(5, 1, 1, 5);
    run_program(w);
    checks++; if (txq.size() !== 8) begin errors++; $display("FAIL br_fetch_count: got %0d required 8", txq.size()); end
    else foreach (exp_f[i]) begin
      checks++; if (txq[i].addr !== exp_f[i]) begin errors++; $display("FAIL br_fetch_%0d: got %h required %h", i, txq[i].addr, exp_f[i]); end
    end
    checks++; if (cycles !== 26 + 8 * w) begin errors++; $display("FAIL br_cycles: got %0d required %0d", cycles, 26 + 8 * w); end
  endtask

  task automatic test_zero_reg();
    clear_mem();
    mem[4] = 32'h1234_5678;
    put(enc_i(8, 0, 0, 7)); put(enc_r(0, 0, 6, 0, 'h20)); put(enc_i('h2B, 0, 6, 4)); put(ILLEGAL);
    run_program(1);
    checks++; if (wbq.size() !== 1 || wbq[0] !== mk_wb(6, 0)) begin errors++; $display("FAIL zero_regwrite: got %0d writes first=%h required 1 write r6=0", wbq.size(), (wbq.size() > 0) ? wbq[0] : '0); end
    checks++; if (mem[4] !== 32'h0) begin errors++; $display("FAIL zero_value: got %h required 0", mem[4]); end
  endtask

  task automatic test_halt();
    logic [31:0] pc0;
    int bad;
    clear_mem();
    put(enc_i(8, 0, 1, 3)); put(ILLEGAL);
    run_program(0);
    checks++; if (halted !== 1'b1 || pc !== 32'h12) begin errors++; $display("FAIL halt_state: got halted=%b pc=%h required 1 12", halted, pc); end
    pc0 = 32'h12; bad = 0;
    repeat (10) begin @(negedge clock); if (mem_req !== 1'b0 || pc !== pc0 || halted !== 1'b1 || instruction !== ILLEGAL) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL halt_frozen: got %0d bad cycles required 0", bad); end
    reset_n = 1'b0; #1;
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_reset: got %b required 0", halted); end
    clear_mem();
    put(enc_r(1, 2, 3, 0, 'h21));
    run_program(0);
    checks++; if (cycles !== 2 || halted !== 1'b1) begin errors++; $display("FAIL halt_funct: got cycles=%0d halted=%b required 2 1", cycles, halted); end
  endtask

  task automatic test_random();
    int fns [5] = '{'h20, 'h22, 'h24, 'h25, 'h2A};
    int sel, rs, rt, rd, w;
    for (int it = 0; it < 8; it++) begin
      clear_mem();
      for (int i = 'h300; i < 'h310; i++) mem[i] = $urandom;
      for (int k = 0; k < 12; k++) begin
        sel = $urandom_range(0, 13); rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
        case (sel)
          0, 1, 2, 3, 4: put(enc_r(rs, rt, rd, 0, fns[sel]));
          5:  put(enc_r(0, rt, rd, $urandom_range(0, 31), 'h00));
          6:  put(enc_r(0, rt, rd, $urandom_range(0, 31), 'h02));
          7:  put(enc_i('h08, rs, rt, $urandom_range(0, 65535)));
          8:  put(enc_i('h0C, rs, rt, $urandom_range(0, 65535)));
          9:  put(enc_i('h0D, rs, rt, $urandom_range(0, 65535)));
          10: put(enc_i('h23, 0, rt, 'h300 + $urandom_range(0, 15)));
          11: put(enc_i('h2B, 0, rt, 'h300 + $urandom_range(0, 15)));
          12: put(enc_i($urandom_range(4, 5), rs, rt, $urandom_range(1, 2)));
          default: put(enc_j(wp + 2));
        endcase
      end
      for (int r = 1; r < 8; r++) put(enc_i('h2B, 0, r, 'h340 + r));
      w = $urandom_range(0, 3);
      run_program(w);
      checks++; if (tx_diff() !== -1) begin errors++; $display("FAIL rnd%0d_tx: got diff at %0d required -1", it, tx_diff()); end
      checks++; if (wb_diff() !== -1) begin errors++; $display("FAIL rnd%0d_wb: got diff at %0d required -1", it, wb_diff()); end
      checks++; if (cycles !== exp_cycles) begin errors++; $display("FAIL rnd%0d_cycles: got %0d required %0d", it, cycles, exp_cycles); end
      checks++; if (unstable !== 0) begin errors++; $display("FAIL rnd%0d_stable: got %0d changes required 0", it, unstable); end
    end
  endtask

  initial begin
    mem_ready = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_zero_reg();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks so far", checks);
    $fatal(1);
  end
endmodule
